// File: rtl/arith_seq_unit.sv
// arith_seq_unit: handshaked ADD/SUB unit with optional iterative MUL.
// Define ARITH_SEQ_UNIT_MUL_EN to build the shift-add multiplier.
module arith_seq_unit #(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [OPERAND_WIDTH-1:0] lhs,
  input  logic [OPERAND_WIDTH-1:0] rhs,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] res,
  output logic                     carry,
  output logic                     zero,
  output logic                     err
);

  localparam int W  = OPERAND_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t   state;
  logic [W:0] sum;
  logic [W:0] dif;

  // Extra top bit gives carry-out for ADD and borrow for SUB
  always_comb begin
    sum = {1'b0, lhs} + {1'b0, rhs};
    dif = {1'b0, lhs} - {1'b0, rhs};
  end

`ifdef ARITH_SEQ_UNIT_MUL_EN
  localparam int CW = $clog2(W + 1);
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      res       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
`ifdef ARITH_SEQ_UNIT_MUL_EN
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            err      <= 1'b0;
            unique case (op)
              2'b00: begin
                res       <= sum[W-1:0];
                carry     <= sum[W];
                zero      <= (sum[W-1:0] == '0);
                out_valid <= 1'b1;
                state     <= DONE;
              end
              2'b01: begin
                res       <= dif[W-1:0];
                carry     <= dif[W];
                zero      <= (dif[W-1:0] == '0);
                out_valid <= 1'b1;
                state     <= DONE;
              end
`ifdef ARITH_SEQ_UNIT_MUL_EN
              2'b10: begin
                mcand  <= {{W{1'b0}}, lhs};
                mplier <= rhs;
                acc    <= '0;
                cnt    <= '0;
                state  <= EXEC;
              end
`endif
              default: begin
                res       <= '0;
                carry     <= 1'b0;
                zero      <= 1'b1;
                err       <= 1'b1;
                out_valid <= 1'b1;
                state     <= DONE;
              end
            endcase
          end
        end
        EXEC: begin
`ifdef ARITH_SEQ_UNIT_MUL_EN
          // One partial product per cycle; an extra cycle publishes
          if (cnt == CW'(W)) begin
            res       <= acc[W-1:0];
            carry     <= |acc[2*W-1:W];
            zero      <= (acc[W-1:0] == '0);
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_seq_unit.sv
// tb_arith_seq_unit: directed scoreboard bench for arith_seq_unit, W=8.
// Expectations follow ARITH_SEQ_UNIT_MUL_EN when it is defined.
module tb_arith_seq_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] lhs;
  logic [W-1:0] rhs;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         carry;
  logic         zero;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic       zero;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  arith_seq_unit #(.OPERAND_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .lhs(lhs),
    .rhs(rhs),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res(res),
    .carry(carry),
    .zero(zero),
    .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [7:0] a,
                                 input logic [7:0] b);
    exp_t e;
    int unsigned p;
    e.res   = 8'h00;
    e.carry = 1'b0;
    e.err   = 1'b1;
    e.lat   = 1;
    if (o == 2'b00) begin
      p = int'(a) + int'(b);
      e.res = p[7:0];
      e.carry = (p > 255);
      e.err = 1'b0;
    end else if (o == 2'b01) begin
      p = int'(a) - int'(b);
      e.res = p[7:0];
      e.carry = (a < b);
      e.err = 1'b0;
    end
`ifdef ARITH_SEQ_UNIT_MUL_EN
    else if (o == 2'b10) begin
      p = int'(a) * int'(b);
      e.res = p[7:0];
      e.carry = (p > 255);
      e.err = 1'b0;
      e.lat = W + 1;
    end
`endif
    e.zero = (e.res == 8'h00);
    return e;
  endfunction

  task automatic run(input string tag, input logic [1:0] o,
                     input logic [7:0] a, input logic [7:0] b,
                     input int hold);
    exp_t e;
    int cyc;
    logic [7:0] r0;
    sb.push_back(model(o, a, b));
    @(negedge clk);
    op = o; lhs = a; rhs = b;
    in_valid = 1'b1; out_ready = 1'b0;
    check({tag, ".rdy"}, in_ready, 1);
    @(posedge clk); #1;
    // Garbage on the request side must be ignored until IDLE
    op = 2'($urandom); lhs = 8'($urandom); rhs = 8'($urandom);
    out_ready = 1'b1;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    e = sb.pop_front();
    check({tag, ".lat"}, cyc, e.lat);
    check({tag, ".res"}, res, e.res);
    check({tag, ".carry"}, carry, e.carry);
    check({tag, ".zero"}, zero, e.zero);
    check({tag, ".err"}, err, e.err);
    check({tag, ".busy"}, in_ready, 0);
    r0 = res;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hv"}, out_valid, 1);
      check({tag, ".hres"}, res, r0);
      check({tag, ".hrdy"}, in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".ov0"}, out_valid, 0);
    check({tag, ".idle"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; lhs = '0; rhs = '0;
    #12;
    check("rst.rdy", in_ready, 0);
    check("rst.ov", out_valid, 0);
    check("rst.res", res, 0);
    check("rst.carry", carry, 0);
    check("rst.zero", zero, 0);
    check("rst.err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rel.rdy0", in_ready, 0);
    @(posedge clk); #1;
    check("rel.rdy1", in_ready, 1);

    run("add_f0_20", 2'b00, 8'hF0, 8'h20, 0);
    run("sub_5_5", 2'b01, 8'h05, 8'h05, 0);
    run("sub_3_4", 2'b01, 8'h03, 8'h04, 0);
    run("add_bp", 2'b00, 8'h01, 8'h02, 5);
    run("op11", 2'b11, 8'h5A, 8'hA5, 0);
    run("op10", 2'b10, 8'h10, 8'h10, 0);
    run("op10b", 2'b10, 8'h0C, 8'h0B, 0);
    run("mul_ff", 2'b10, 8'hFF, 8'hFF, 2);
    run("add_ff_01", 2'b00, 8'hFF, 8'h01, 0);
    run("sub_0_0", 2'b01, 8'h00, 8'h00, 0);
    for (int i = 0; i < 6; i++)
      run("rnd", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1);

    // Reset in the middle of a transaction: nothing may emerge
    @(negedge clk);
`ifdef ARITH_SEQ_UNIT_MUL_EN
    op = 2'b10;
`else
    op = 2'b00;
`endif
    lhs = 8'h37; rhs = 8'h11; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mrst.ov", out_valid, 0);
    check("mrst.rdy", in_ready, 0);
    check("mrst.res", res, 0);
    check("mrst.carry", carry, 0);
    check("mrst.zero", zero, 0);
    check("mrst.err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    #1 check("mrst.rdy0", in_ready, 0);
    @(posedge clk); #1;
    check("mrst.rdy1", in_ready, 1);
    begin
      int seen;
      seen = 0;
      repeat (15) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("mrst.noout", seen, 0);
    end
    out_ready = 1'b0;
    run("post_rst", 2'b00, 8'h22, 8'h33, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_seq_unit.md
ARITH_SEQ_UNIT -- requirements
Module: arith_seq_unit

Interface
REQ-001 The block SHALL have parameter OPERAND_WIDTH, default 32, giving the operand and result width in bits; legal range 4..64.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port in_valid  input  1  request present.
REQ-005 The block SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 The block SHALL have port op  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
REQ-007 The block SHALL have port lhs  input  OPERAND_WIDTH  left operand, unsigned.
REQ-008 The block SHALL have port rhs  input  OPERAND_WIDTH  right operand, unsigned.
REQ-009 The block SHALL have port out_valid  output  1  result present.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have port res  output  OPERAND_WIDTH  result.
REQ-012 The block SHALL have port carry  output  1  ADD carry-out, SUB borrow, MUL overflow.
REQ-013 The block SHALL have port zero  output  1  res equals 0.
REQ-014 The block SHALL have port err  output  1  illegal or disabled op.

Function
REQ-015 The block SHALL implement FSM states IDLE, EXEC, DONE.
REQ-016 The block SHALL drive in_ready=1 only in IDLE; request accepted on the clk edge where in_valid and in_ready are both 1; op, lhs, rhs captured then.
REQ-017 The block SHALL, on accepted ADD, SUB or reserved op, go IDLE->DONE (latency 1 cycle to out_valid).
REQ-018 The block SHALL, on accepted MUL, go IDLE->EXEC, run one shift-add step per cycle for OPERAND_WIDTH cycles, then EXEC->DONE (latency OPERAND_WIDTH+1).
REQ-019 The block SHALL compute ADD res = (lhs+rhs) mod 2^W, carry = bit W of the W+1-bit sum.
REQ-020 The block SHALL compute SUB res = (lhs-rhs) mod 2^W, carry = 1 iff lhs < rhs.
REQ-021 The block SHALL compute MUL res = low W bits of the 2W-bit product, carry = 1 iff the high W bits are nonzero.
REQ-022 The block SHALL, for op 11, return res=0, carry=0, zero=1, err=1; err=0 for legal ops.
REQ-023 The block SHALL drive out_valid=1 only in DONE and hold res, carry, zero, err stable while out_valid=1 and out_ready=0.
REQ-024 The block SHALL go DONE->IDLE on out_valid and out_ready both 1; no new request accepted in that same cycle.
REQ-025 The block SHALL ignore in_valid, op, lhs, rhs while in EXEC or DONE.
REQ-026 The block SHALL ignore out_ready outside DONE.

Reset
REQ-027 The block SHALL, while rst=0, force state IDLE, in_ready=0, out_valid=0, res=0, carry=0, zero=0, err=0, and clear the multiplier step counter and accumulator.
REQ-028 The block SHALL raise in_ready=1 on the first rising clk edge after rst deasserts.
REQ-029 The block SHALL abandon any in-flight operation (EXEC or DONE) on reset assertion with no result ever presented.

Configuration
REQ-030 The block SHALL compile the iterative multiplier only when macro ARITH_SEQ_UNIT_MUL_EN is defined.
REQ-031 The block SHALL, with ARITH_SEQ_UNIT_MUL_EN undefined, treat op 10 like op 11 (latency 1, res=0, zero=1, err=1) and never enter EXEC.

Verification
REQ-032 The bench SHALL cover, W=8: ADD lhs=0xF0 rhs=0x20 -> one cycle after acceptance out_valid=1, res=0x10, carry=1, zero=0, err=0.
REQ-033 The bench SHALL cover, W=8: SUB lhs=0x05 rhs=0x05 -> res=0x00, carry=0, zero=1; SUB 0x03-0x04 -> res=0xFF, carry=1.
REQ-034 The bench SHALL cover, W=8, MUL_EN defined: MUL 0x10*0x10 -> out_valid exactly 9 cycles after acceptance, res=0x00, carry=1, zero=1; MUL 0x0C*0x0B -> res=0x84, carry=0.
REQ-035 The bench SHALL cover backpressure: ADD 1+2 with out_ready=0 for 5 cycles -> out_valid and res=0x03 held, in_ready=0 throughout, returns to IDLE after out_ready=1 handshake.
REQ-036 The bench SHALL cover op=11, and op=10 with MUL_EN undefined -> res=0, zero=1, err=1, latency 1.
REQ-037 The bench SHALL cover rst=0 asserted mid-MUL (cycle 4 of EXEC) -> all outputs 0 immediately, no out_valid after release, in_ready=1 one edge after release.
